// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared constants and types for the FPU multiply path.
//   FPU_EXP_W / FPU_SIG_W : default biased-exponent and significand widths
//                           (significand width includes the hidden bit).
//   fpu_max_exp()         : all-ones biased exponent for a given width; any
//                           adjusted exponent at or above it is an overflow.
//   norm_res_t            : normaliser result record {sig, exp, of, uf} at
//                           the default widths; sig is {significand, R, S}.
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int FPU_EXP_W = 8;
    localparam int FPU_SIG_W = 24;

    function automatic int fpu_max_exp(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    localparam int FPU_MAX_EXP = fpu_max_exp(FPU_EXP_W);

    typedef struct packed {
        logic [FPU_SIG_W+1:0] sig;
        logic [FPU_EXP_W-1:0] exp;
        logic                 of;
        logic                 uf;
    } norm_res_t;

endpackage

// File: rtl/fpu_mul_norm.sv
// ---------------------------------------------------------------------------
// fpu_mul_norm
// Purely combinational normaliser for the raw significand product.
// Finds the leading one, shifts the product so the result window holds a
// normalised (or subnormal) significand, keeps an exact sticky bit over
// every bit shifted out, and adjusts the exponent.
// Ports:
//   prod    in  2*SIG_W  raw product sig_a*sig_b
//   pre_exp in  EXP_W+1  pre-normalisation exponent (unsigned, or two's
//                        complement <= 0 when exp_uf=1)
//   exp_uf  in  1        pre_exp is below 1
//   sig     out SIG_W+2  {normalised significand, R, S}
//   exp     out EXP_W    result biased exponent
//   of      out 1        overflow
//   uf      out 1        result is subnormal and nonzero
// ---------------------------------------------------------------------------
module fpu_mul_norm
    import fpu_pkg::*;
#(
    parameter int EXP_W = FPU_EXP_W,
    parameter int SIG_W = FPU_SIG_W
) (
    input  logic [2*SIG_W-1:0] prod,
    input  logic [EXP_W:0]     pre_exp,
    input  logic               exp_uf,
    output logic [SIG_W+1:0]   sig,
    output logic [EXP_W-1:0]   exp,
    output logic               of,
    output logic               uf
);

    localparam int PW   = 2 * SIG_W;
    localparam int T    = PW - 1;
    localparam int SH_W = $clog2(PW + 1);
    // Wide enough for pre_exp+1 and for 1-pre_exp without wrapping.
    localparam int EW   = EXP_W + SH_W + 2;
    localparam logic [EW-1:0] MAX_E = EW'(fpu_max_exp(EXP_W));

    logic [SH_W-1:0] lz;
    logic [SH_W-1:0] lsh;
    logic [SH_W-1:0] rsh;
    logic [EW-1:0]   pe;
    logic [EW-1:0]   pe_neg;
    logic [EW-1:0]   rs_full;
    logic [EW-1:0]   e_adj;
    logic [PW-2:0]   shifted;
    logic            lost;

    // Leading zeros of P[T-1:0]; the highest set bit wins because it is
    // visited last.
    always_comb begin
        lz = SH_W'(T);
        for (int i = 0; i < T; i++) begin
            if (prod[i]) begin
                lz = SH_W'(T - 1 - i);
            end
        end
    end

    // Shift selection and exponent adjust. Left shifts never push a set bit
    // above T-1, so only the right shifts can lose bits into the sticky.
    always_comb begin
        pe      = EW'(pre_exp);
        pe_neg  = ~{{(EW-EXP_W-1){pre_exp[EXP_W]}}, pre_exp} + EW'(1);
        rs_full = pe_neg + EW'(1);
        lsh     = '0;
        rsh     = '0;
        e_adj   = '0;
        if (!exp_uf) begin
            if (prod[T]) begin
                rsh   = SH_W'(1);
                e_adj = pe + EW'(1);
            end else if (prod[T-1]) begin
                e_adj = pe;
            end else if (pe <= EW'(lz)) begin
                // Cannot fully normalise: land on the subnormal exponent.
                if (pe == '0) begin
                    rsh = SH_W'(1);
                end else begin
                    lsh = SH_W'(pe - EW'(1));
                end
            end else begin
                e_adj = pe - EW'(lz);
                lsh   = lz;
            end
        end else if (rs_full > EW'(PW)) begin
            rsh = SH_W'(PW);
        end else begin
            rsh = SH_W'(rs_full);
        end

        shifted = (PW-1)'((prod << lsh) >> rsh);
        lost    = |(prod & ~({PW{1'b1}} << rsh));

        // A subnormal input can round back up into the normal range only by
        // landing its leading one on the hidden-bit position.
        if (exp_uf) begin
            e_adj = EW'(shifted[T-1]);
        end

        sig = '0;
        exp = '0;
        of  = 1'b0;
        uf  = 1'b0;
        if (prod != '0) begin
            if (!exp_uf && (e_adj >= MAX_E)) begin
                of  = 1'b1;
                exp = '1;
            end else begin
                sig = {shifted[T-1 -: SIG_W], shifted[T-1-SIG_W],
                       (|shifted[T-2-SIG_W:0]) | lost};
                exp = e_adj[EXP_W-1:0];
                uf  = (e_adj == '0);
            end
        end
    end

endmodule

// File: rtl/fpu_mul_pipe.sv
// ---------------------------------------------------------------------------
// fpu_mul_pipe
// Pipelined significand multiplier and normaliser with valid/ready
// handshake, stall and flush. MUL_STAGES product registers are followed by
// one normaliser output register (latency MUL_STAGES+1, throughput 1/cycle).
// Optional feature macro FPU_MUL_INEXACT_EN adds out_inexact = R|S of the
// registered result (0 on overflow).
// Ports:
//   clk, reset (sync, active high), flush (drops in-flight operations)
//   in_valid/in_ready, sig_a, sig_b, pre_exp, exp_uf : operand side
//   out_valid/out_ready, out_sig {sig,R,S}, out_exp, out_of, out_uf
//   [out_inexact]                                    : result side
// ---------------------------------------------------------------------------
module fpu_mul_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W      = FPU_EXP_W,
    parameter int SIG_W      = FPU_SIG_W,
    parameter int MUL_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SIG_W-1:0]   sig_a,
    input  logic [SIG_W-1:0]   sig_b,
    input  logic [EXP_W:0]     pre_exp,
    input  logic               exp_uf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIG_W+1:0]   out_sig,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_of,
    output logic               out_uf
`ifdef FPU_MUL_INEXACT_EN
    ,
    output logic               out_inexact
`endif
);

    localparam int PW = 2 * SIG_W;
    localparam int LS = MUL_STAGES - 1;

    logic                  advance;
    logic [MUL_STAGES-1:0] vld_q;
    logic [PW-1:0]         prod_q [MUL_STAGES];
    logic [EXP_W:0]        exp_q  [MUL_STAGES];
    logic [MUL_STAGES-1:0] uf_q;
    logic [SIG_W+1:0]      n_sig;
    logic [EXP_W-1:0]      n_exp;
    logic                  n_of;
    logic                  n_uf;

    // The whole pipe moves as one unit whenever the output slot is free.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Data path registers carry no reset; only the valid bits decide
    // whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (advance) begin
            prod_q[0] <= PW'(sig_a) * PW'(sig_b);
            exp_q[0]  <= pre_exp;
            uf_q[0]   <= exp_uf;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                exp_q[i]  <= exp_q[i-1];
                uf_q[i]   <= uf_q[i-1];
            end
        end
    end

    fpu_mul_norm #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W)
    ) u_norm (
        .prod    (prod_q[LS]),
        .pre_exp (exp_q[LS]),
        .exp_uf  (uf_q[LS]),
        .sig     (n_sig),
        .exp     (n_exp),
        .of      (n_of),
        .uf      (n_uf)
    );

    // Valid pipeline and output register. Flush clears every valid bit, so an
    // operand offered in the same cycle never enters the pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            out_valid   <= 1'b0;
            out_sig     <= '0;
            out_exp     <= '0;
            out_of      <= 1'b0;
            out_uf      <= 1'b0;
`ifdef FPU_MUL_INEXACT_EN
            out_inexact <= 1'b0;
`endif
        end else if (flush) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
        end else if (advance) begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < MUL_STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            out_valid <= vld_q[LS];
            if (vld_q[LS]) begin
                out_sig     <= n_sig;
                out_exp     <= n_exp;
                out_of      <= n_of;
                out_uf      <= n_uf;
`ifdef FPU_MUL_INEXACT_EN
                out_inexact <= (n_sig[1] | n_sig[0]) & ~n_of;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fpu_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_fpu_mul_pipe
// Self-checking bench for fpu_mul_pipe at default widths (EXP_W=8, SIG_W=24,
// MUL_STAGES=2). Directed cases plus randomized operands are scored against
// a reference model built from leading-one position and a signed net shift.
// ---------------------------------------------------------------------------
module tb_fpu_mul_pipe;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] sig_a;
    logic [23:0] sig_b;
    logic [8:0]  pre_exp;
    logic        exp_uf;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_sig;
    logic [7:0]  out_exp;
    logic        out_of;
    logic        out_uf;
`ifdef FPU_MUL_INEXACT_EN
    logic        out_inexact;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_count = 0;
    int stall_seen = 0;
    int stall_from = 0;
    int stall_to = -1;
    bit rand_ready = 0;
    bit lat_check = 0;

    norm_res_t   exp_q[$];
    int          cyc_q[$];
    logic [25:0] last_sig;
    logic [7:0]  last_exp;
    logic        last_of;
    logic        last_uf;

    always #5 clk = ~clk;

    fpu_mul_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sig_a     (sig_a),
        .sig_b     (sig_b),
        .pre_exp   (pre_exp),
        .exp_uf    (exp_uf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sig   (out_sig),
        .out_exp   (out_exp),
        .out_of    (out_of),
`ifdef FPU_MUL_INEXACT_EN
        .out_inexact (out_inexact),
`endif
        .out_uf    (out_uf)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: locate the leading one, pick a signed net shift (positive =
    // right), apply it to the full product and read the result window.
    function automatic norm_res_t refModel(input logic [23:0] a, input logic [23:0] b,
                                           input logic [8:0] pe, input logic uf);
        norm_res_t   r;
        logic [63:0] p;
        logic [63:0] pp;
        int          msb;
        int          k;
        int          e;
        int          pv;
        int          z;
        logic        lost;
        r = '0;
        p = 64'(a) * 64'(b);
        if (p == 64'd0) return r;
        msb = 0;
        for (int i = 0; i < 48; i++) if (p[i]) msb = i;
        e = 0;
        if (!uf) begin
            pv = int'(pe);
            if (msb == 47) begin
                k = 1; e = pv + 1;
            end else if (msb == 46) begin
                k = 0; e = pv;
            end else begin
                z = 46 - msb;
                if (pv <= z) begin
                    e = 0;
                    k = (pv == 0) ? 1 : -(pv - 1);
                end else begin
                    e = pv - z;
                    k = -z;
                end
            end
        end else begin
            pv = int'($signed(pe));
            k = 1 - pv;
            if (k > 48) k = 48;
        end
        if (k >= 0) begin
            pp   = p >> k;
            lost = (p & ((64'd1 << k) - 64'd1)) != 64'd0;
        end else begin
            pp   = p << (-k);
            lost = 1'b0;
        end
        if (uf) e = pp[46] ? 1 : 0;
        if (!uf && e >= FPU_MAX_EXP) begin
            r.of  = 1'b1;
            r.exp = 8'hFF;
        end else begin
            r.sig = {pp[46:23], pp[22], (pp[21:0] != 22'd0) | lost};
            r.exp = 8'(e);
            r.uf  = (e == 0);
        end
        return r;
    endfunction

    // One clock: set out_ready, sample at negedge, score any delivered
    // result, log any accepted operand, then move to 1 time unit past posedge.
    task automatic stepCycle(output bit accepted);
        norm_res_t want;
        int        c;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        else            out_ready = !(cyc >= stall_from && cyc <= stall_to);
        @(negedge clk);
        if (!in_ready) stall_seen++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                want = exp_q.pop_front();
                c    = cyc_q.pop_front();
                checkOutput("sig", 64'(out_sig), 64'(want.sig));
                checkOutput("exp", 64'(out_exp), 64'(want.exp));
                checkOutput("of",  64'(out_of),  64'(want.of));
                checkOutput("uf",  64'(out_uf),  64'(want.uf));
`ifdef FPU_MUL_INEXACT_EN
                checkOutput("inexact", 64'(out_inexact),
                            64'((want.sig[1] | want.sig[0]) & ~want.of));
`endif
                if (lat_check) checkOutput("latency", 64'(cyc - c), 64'd3);
                last_sig = out_sig;
                last_exp = out_exp;
                last_of  = out_of;
                last_uf  = out_uf;
                pop_count++;
            end
        end
        accepted = in_valid && in_ready && !reset && !flush;
        if (accepted) begin
            exp_q.push_back(refModel(sig_a, sig_b, pre_exp, exp_uf));
            cyc_q.push_back(cyc);
        end
        if (reset || flush) begin
            exp_q.delete();
            cyc_q.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b,
                                 input logic [8:0] pe, input logic uf);
        bit acc;
        int tries;
        sig_a    = a;
        sig_b    = b;
        pre_exp  = pe;
        exp_uf   = uf;
        in_valid = 1'b1;
        acc      = 1'b0;
        tries    = 0;
        while (!acc && tries < 100) begin
            stepCycle(acc);
            tries++;
        end
        if (!acc) checkOutput("accept_timeout", 64'(tries), 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            stepCycle(acc);
            n++;
        end
        checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic genOperand(output logic [23:0] a, output logic [23:0] b,
                              output logic [8:0] pe, output logic uf);
        int m;
        m = int'($urandom_range(0, 9));
        a = {1'b1, 23'($urandom)};
        b = {1'b1, 23'($urandom)};
        if (m == 0) a = 24'($urandom_range(0, 255));
        else if (m == 1) begin
            a = 24'($urandom_range(0, 4095));
            b = 24'($urandom_range(0, 4095));
        end else if (m == 2) b = 24'd0;
        uf = ($urandom_range(0, 3) == 0);
        if (uf) begin
            if ($urandom_range(0, 7) == 0) pe = 9'(0 - int'($urandom_range(0, 256)));
            else                           pe = 9'(0 - int'($urandom_range(0, 50)));
        end else begin
            case ($urandom_range(0, 3))
                0:       pe = 9'($urandom_range(0, 60));
                1:       pe = 9'($urandom_range(240, 511));
                default: pe = 9'($urandom_range(60, 300));
            endcase
        end
    endtask

    task automatic flushOrResetMidFlight(input bit use_reset);
        bit acc;
        int p0;
        rand_ready = 0; stall_from = 0; stall_to = -1;
        p0 = pop_count;
        applyStimulus(24'h800000, 24'h800000, 9'd127, 1'b0);
        applyStimulus(24'hC00000, 24'hC00000, 9'd127, 1'b0);
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        stepCycle(acc);
        reset = 1'b0;
        flush = 1'b0;
        checkOutput(use_reset ? "rst_mid_valid" : "flush_mid_valid", 64'(out_valid), 64'd0);
        if (use_reset) checkOutput("rst_mid_sig", 64'(out_sig), 64'd0);
        for (int i = 0; i < 6; i++) begin
            stepCycle(acc);
            checkOutput(use_reset ? "rst_mid_quiet" : "flush_mid_quiet", 64'(out_valid), 64'd0);
        end
        checkOutput(use_reset ? "rst_mid_pops" : "flush_mid_pops", 64'(pop_count - p0), 64'd0);
    endtask

    initial begin
        bit          acc;
        int          base;
        int          p0;
        logic [23:0] ra;
        logic [23:0] rb;
        logic [8:0]  rpe;
        logic        ruf;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sig_a = '0; sig_b = '0; pre_exp = '0; exp_uf = 1'b0;
        repeat (3) stepCycle(acc);
        reset = 1'b0;
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_sig",   64'(out_sig),   64'd0);
        checkOutput("rst_exp",   64'(out_exp),   64'd0);
        checkOutput("rst_of",    64'(out_of),    64'd0);
        checkOutput("rst_uf",    64'(out_uf),    64'd0);
        checkOutput("rst_ready", 64'(in_ready),  64'd1);

        // Directed cases with hand-derived results.
        lat_check = 1;
        applyStimulus(24'h800000, 24'h800000, 9'd127, 1'b0); drain();
        checkOutput("one_sig", 64'(last_sig), 64'({24'h800000, 2'b00}));
        checkOutput("one_exp", 64'(last_exp), 64'd127);
        checkOutput("one_ofuf", 64'({last_of, last_uf}), 64'd0);

        applyStimulus(24'hC00000, 24'hC00000, 9'd127, 1'b0); drain();
        checkOutput("p15_sig", 64'(last_sig), 64'({24'h900000, 2'b00}));
        checkOutput("p15_exp", 64'(last_exp), 64'd128);

        applyStimulus(24'hC00000, 24'hC00000, 9'd254, 1'b0); drain();
        checkOutput("ovf_of",  64'(last_of),  64'd1);
        checkOutput("ovf_exp", 64'(last_exp), 64'hFF);
        checkOutput("ovf_sig", 64'(last_sig), 64'd0);

        applyStimulus(24'h800000, 24'h800000, 9'h1FF, 1'b1); drain();
        checkOutput("sub_sig", 64'(last_sig), 64'({24'h200000, 2'b00}));
        checkOutput("sub_exp", 64'(last_exp), 64'd0);
        checkOutput("sub_uf",  64'(last_uf),  64'd1);

        applyStimulus(24'h800001, 24'h800000, 9'h1FF, 1'b1); drain();
        checkOutput("sticky_sig", 64'(last_sig), 64'({24'h200000, 2'b01}));

        // Backpressure: out_ready low for cycles 3..5 of a 4-operand burst.
        lat_check = 0;
        base = cyc; stall_from = base + 3; stall_to = base + 5;
        stall_seen = 0; p0 = pop_count;
        applyStimulus(24'h800000, 24'h800000, 9'd127, 1'b0);
        applyStimulus(24'hC00000, 24'hC00000, 9'd127, 1'b0);
        applyStimulus(24'hA00000, 24'h900000, 9'd100, 1'b0);
        applyStimulus(24'h000123, 24'h800000, 9'd10,  1'b0);
        drain();
        checkOutput("bp_stall_cycles", 64'(stall_seen), 64'd3);
        checkOutput("bp_pops", 64'(pop_count - p0), 64'd4);
        checkOutput("bp_last_exp", 64'(last_exp), 64'd0);

        flushOrResetMidFlight(1'b1);
        flushOrResetMidFlight(1'b0);

        // Randomized operands, random gaps, random backpressure.
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                stepCycle(acc);
            end
            genOperand(ra, rb, rpe, ruf);
            applyStimulus(ra, rb, rpe, ruf);
        end
        drain();

        // Randomized, full throughput with fixed latency.
        rand_ready = 0; stall_from = 0; stall_to = -1; lat_check = 1;
        for (int n = 0; n < 100; n++) begin
            genOperand(ra, rb, rpe, ruf);
            applyStimulus(ra, rb, rpe, ruf);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
